slow_tick_timer: RTL and testbench
==================================

# slow_tick_timer

Downstream consumer of the clock divider output. Brings the divided clock into the `clk_i` domain through a synchronizer and detects its rising edges as single-cycle ticks. Counts those ticks in a programmable one-shot or periodic down-counter that signals expiry. It lets control logic schedule events on the slow time base without clocking any flops from the divided clock.

## Interface
Parameters:
- `WIDTH`, default 16: tick counter and load value width.
- `SYNC_STAGES`, default 2: synchronizer flop count. Legal minimum is 2.

Ports:
- `clk_i`  in  1  system clock. The sole clock of the block.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `div_clk_i`  in  1  divided clock from the clock divider. Treated as asynchronous data.
- `start_i`  in  1  load the counter and enter RUN. Level-sampled each cycle.
- `stop_i`  in  1  abort and return to IDLE.
- `periodic_i`  in  1  mode select, captured at start: 1 = auto-reload, 0 = one-shot.
- `load_val_i`  in  WIDTH  tick count to expiry, captured at start.
- `tick_o`  out  1  one-cycle pulse per `div_clk_i` rising edge. Independent of state.
- `expire_o`  out  1  one-cycle pulse on the final tick of a count.
- `busy_o`  out  1  high in RUN.
- `count_o`  out  WIDTH  ticks remaining.

## Operation
- Synchronizer chain `s[0..SYNC_STAGES-1]` resets to 0. Previous-value flop `p` resets to 1.
  - Because `p` resets to 1, a `div_clk_i` already high at reset release produces no tick.
- Internal edge `e = s[last] & ~p`.
- `tick_o` is registered from `e`. `p <= s[last]` every cycle.
- Effective load value `L = (load_val_i == 0) ? 1 : load_val_i`. Zero means expire on the first tick.
- Holding registers: `reload` (WIDTH) and `mode` (1 bit).
- FSM states: IDLE and RUN.
  - IDLE, `start_i=1`, `stop_i=0`: `count <= L`, `reload <= L`, `mode <= periodic_i`, go to RUN. Ticks in that cycle are ignored.
  - RUN, `stop_i=1`: go to IDLE, `count <= 0`. No `expire_o`, even if `e` is high the same cycle.
  - RUN, `start_i=1` (no stop): restart. Reload from the new `L`, recapture mode. Any `e` in the same cycle is ignored.
  - RUN, `e=1` and `count > 1`: `count <= count - 1`.
  - RUN, `e=1` and `count == 1`: `expire_o <= 1`.
    - `mode=1`: `count <= reload`, stay in RUN.
    - `mode=0`: `count <= 0`, go to IDLE.
- Priority in any cycle: `stop_i` > `start_i` > tick.
- `count` never wraps or underflows. It is never 0 while in RUN.
- `load_val_i` and `periodic_i` are ignored outside start cycles.

## Timing
Reset values:
- All outputs are 0.
- State is IDLE; `count`, `reload` and `mode` are 0; `p` is 1.
- Reset asserted mid-count aborts immediately and asynchronously, with no `expire_o`.

Latency and pulse rules:
- `div_clk_i` rises with setup met before edge E0.
  - `tick_o` is high from edge E(`SYNC_STAGES`) to E(`SYNC_STAGES`+1).
  - For the default, that is high during the cycle after E2.
- `tick_o` is exactly one cycle wide regardless of how long `div_clk_i` stays high.
- A `div_clk_i` high pulse shorter than one `clk_i` period may be missed. The divided clock must hold each level for at least 2 `clk_i` cycles.
- `expire_o` rises on the same edge as the final `tick_o`.
- In one-shot mode, `busy_o` falls and `count_o` becomes 0 on that same edge.
- From a start cycle at edge S, `busy_o` and `count_o = L` are visible after S.
- Periodic mode: consecutive `expire_o` pulses are separated by exactly `L` ticks.

## Test plan
- Reset release with `div_clk_i` held high for 10 cycles, then low: no `tick_o`.
  - Then a rise produces a `tick_o` 2 cycles after the rise (default `SYNC_STAGES`).
- `div_clk_i` period 8 `clk_i`; one-shot start with `load_val_i=3`.
  - `count_o` steps 3→2→1, one step per tick.
  - `expire_o` and the third `tick_o` are coincident.
  - `busy_o` falls and `count_o=0` on that same edge.
- Periodic start with `load_val_i=2` over 7 ticks: `expire_o` on ticks 2, 4, 6; `busy_o` stays 1; `count_o` reloads to 2.
- `load_val_i=0`, one-shot: `count_o=1`, then `expire_o` on the first tick.
- `stop_i` and the final tick in the same cycle: no `expire_o`, IDLE, `count_o=0`.
- `start_i` with `load_val_i=5` in the same cycle as a tick while `count=1`:
  - No `expire_o`; `count_o=5`.
- Reset asserted mid-count: `busy_o`, `count_o` and `expire_o` drop to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/slow_tick_timer.sv
// slow_tick_timer
// Synchronizes a divided clock into clk_i, turns each of its rising edges into
// a one-cycle tick, and counts those ticks in a one-shot or periodic
// down-counter that pulses expire_o on the final tick of a count.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | counter stopped, count_o = 0, waiting for start_i
// ST_RUN  | counting ticks down from the captured load value, busy_o = 1
module slow_tick_timer #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             div_clk_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             periodic_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tick_o,
    output logic             expire_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] count_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic                   r_prev;
    logic                   r_tick;
    logic                   w_edge;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_count;
    logic [WIDTH-1:0]       w_count_nxt;
    logic [WIDTH-1:0]       r_reload;
    logic [WIDTH-1:0]       w_reload_nxt;
    logic                   r_mode;
    logic                   w_mode_nxt;
    logic                   r_expire;
    logic                   w_expire_nxt;
    logic [WIDTH-1:0]       w_load;

    // The last sync stage still holds its reset zero for the first few cycles
    // after reset. Until a real sample has reached it (r_vld), the previous-
    // value flop is held at 1 so a divided clock that is already high at
    // reset release is not mistaken for a fresh rising edge.
    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

    // Zero would leave RUN with nothing to count; treat it as one tick.
    assign w_load = (load_val_i == '0) ? WIDTH'(1) : load_val_i;

    // Synchronizer chain, edge detector and registered tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
            r_vld  <= '0;
            r_prev <= 1'b1;
            r_tick <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], div_clk_i};
            r_vld  <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_prev <= r_vld[SYNC_STAGES-1] ? r_sync[SYNC_STAGES-1] : 1'b1;
            r_tick <= w_edge;
        end
    end

    // FSM state, counter and holding registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_mode   <= w_mode_nxt;
            r_expire <= w_expire_nxt;
        end
    end

    // Next-state logic; priority is stop, then start, then tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_mode_nxt   = r_mode;
        w_expire_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    w_state_nxt  = ST_RUN;
                    w_count_nxt  = w_load;
                    w_reload_nxt = w_load;
                    w_mode_nxt   = periodic_i;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else if (start_i) begin
                    w_count_nxt  = w_load;
                    w_reload_nxt = w_load;
                    w_mode_nxt   = periodic_i;
                end else if (w_edge) begin
                    if (r_count == WIDTH'(1)) begin
                        w_expire_nxt = 1'b1;
                        if (r_mode) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_count_nxt = '0;
                        end
                    end else begin
                        w_count_nxt = r_count - WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign tick_o   = r_tick;
    assign expire_o = r_expire;
    assign busy_o   = (r_state == ST_RUN);
    assign count_o  = r_count;

endmodule

// File: tb/tb_slow_tick_timer.sv
// Testbench for slow_tick_timer: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a behavioural model.
module tb_slow_tick_timer;

    localparam int W = 16;
    localparam int S = 2;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         div_clk_i;
    logic         start_i;
    logic         stop_i;
    logic         periodic_i;
    logic [W-1:0] load_val_i;
    logic         tick_o;
    logic         expire_o;
    logic         busy_o;
    logic [W-1:0] count_o;

    slow_tick_timer #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .div_clk_i  (div_clk_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .periodic_i (periodic_i),
        .load_val_i (load_val_i),
        .tick_o     (tick_o),
        .expire_o   (expire_o),
        .busy_o     (busy_o),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_chk  = 0;

    // Model: h[k] is the div_clk_i value sampled k+1 edges ago; samples from
    // before reset release count as high, so no tick comes from them.
    bit h [0:7];
    bit m_busy, m_mode, m_tick, m_expire;
    int m_count, m_reload;

    // Divided-clock generation
    bit div_auto = 0;
    bit div_rand = 0;
    int div_half = 4;
    int div_ph   = 0;
    int div_hold = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit pend_e();
        return h[S-1] & ~h[S];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) h[i] = 1'b1;
        m_busy = 0; m_mode = 0; m_tick = 0; m_expire = 0;
        m_count = 0; m_reload = 0;
    endtask

    task automatic model_step();
        bit e;
        int l;
        e = pend_e();
        l = (load_val_i == 0) ? 1 : int'(load_val_i);
        m_tick   = e;
        m_expire = 0;
        if (m_busy) begin
            if (stop_i) begin
                m_busy = 0; m_count = 0;
            end else if (start_i) begin
                m_count = l; m_reload = l; m_mode = periodic_i;
            end else if (e) begin
                if (m_count == 1) begin
                    m_expire = 1;
                    if (m_mode) m_count = m_reload;
                    else begin m_busy = 0; m_count = 0; end
                end else begin
                    m_count = m_count - 1;
                end
            end
        end else if (start_i && !stop_i) begin
            m_busy = 1; m_count = l; m_reload = l; m_mode = periodic_i;
        end
        for (int i = 7; i > 0; i--) h[i] = h[i-1];
        h[0] = div_clk_i;
    endtask

    task automatic compare_all();
        check("m_tick",   int'(tick_o),   int'(m_tick));
        check("m_expire", int'(expire_o), int'(m_expire));
        check("m_busy",   int'(busy_o),   int'(m_busy));
        check("m_count",  int'(count_o),  m_count);
    endtask

    // One clock: drive divided clock, step past the edge, update model, compare.
    task automatic cyc();
        if (div_auto) begin
            div_clk_i = (div_ph < div_half);
            div_ph = (div_ph + 1) % (2 * div_half);
        end else if (div_rand) begin
            if (div_hold == 0) begin
                div_clk_i = ~div_clk_i;
                div_hold = $urandom_range(2, 7);
            end
            div_hold--;
        end
        @(posedge clk_i);
        #1;
        if (rst_i) model_reset();
        else model_step();
        compare_all();
    endtask

    task automatic wait_tick();
        int k = 0;
        do begin
            cyc();
            k++;
        end while (!m_tick && k < 40);
        if (!m_tick) check("wait_tick_timeout", 0, 1);
    endtask

    task automatic advance_to_e();
        int k = 0;
        while (!pend_e() && k < 40) begin
            cyc();
            k++;
        end
        if (!pend_e()) check("advance_e_timeout", 0, 1);
    endtask

    task automatic do_start(input bit per, input int lv);
        start_i = 1; periodic_i = per; load_val_i = W'(lv);
        cyc();
        start_i = 0; periodic_i = $urandom; load_val_i = W'($urandom);
    endtask

    task automatic do_stop();
        stop_i = 1;
        cyc();
        stop_i = 0;
    endtask

    initial begin
        rst_i = 1; div_clk_i = 1; start_i = 0; stop_i = 0;
        periodic_i = 0; load_val_i = '0;
        model_reset();
        repeat (3) cyc();
        check("rst_tick",   int'(tick_o),   0);
        check("rst_expire", int'(expire_o), 0);
        check("rst_busy",   int'(busy_o),   0);
        check("rst_count",  int'(count_o),  0);
        rst_i = 0;

        // div_clk_i high across reset release: no tick
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("no_tick_high_at_release", int'(tick_o), 0);
        end
        div_clk_i = 0;
        repeat (4) cyc();
        div_clk_i = 1;
        cyc();
        cyc();
        check("tick_before_latency", int'(tick_o), 0);
        cyc();
        check("tick_latency", int'(tick_o), 1);
        cyc();
        check("tick_width", int'(tick_o), 0);
        repeat (3) cyc();

        // period-8 divided clock
        div_auto = 1; div_ph = 0; div_half = 4;

        // one-shot, load 3
        do_start(0, 3);
        check("os3_busy", int'(busy_o), 1);
        check("os3_count0", int'(count_o), 3);
        wait_tick();
        check("os3_count1", int'(count_o), 2);
        wait_tick();
        check("os3_count2", int'(count_o), 1);
        check("os3_no_exp", int'(expire_o), 0);
        wait_tick();
        check("os3_tick", int'(tick_o), 1);
        check("os3_expire", int'(expire_o), 1);
        check("os3_busy_fall", int'(busy_o), 0);
        check("os3_count_end", int'(count_o), 0);

        // periodic, load 2, seven ticks
        do_start(1, 2);
        for (int t = 1; t <= 7; t++) begin
            wait_tick();
            check("per2_expire", int'(expire_o), (t % 2 == 0) ? 1 : 0);
            check("per2_busy", int'(busy_o), 1);
            check("per2_count", int'(count_o), (t % 2 == 0) ? 2 : 1);
        end
        do_stop();
        check("per2_stop_busy", int'(busy_o), 0);

        // load 0 means one tick
        do_start(0, 0);
        check("ld0_count", int'(count_o), 1);
        wait_tick();
        check("ld0_expire", int'(expire_o), 1);
        check("ld0_busy", int'(busy_o), 0);

        // stop coincident with final tick
        do_start(0, 1);
        advance_to_e();
        do_stop();
        check("stopfin_tick", int'(tick_o), 1);
        check("stopfin_expire", int'(expire_o), 0);
        check("stopfin_busy", int'(busy_o), 0);
        check("stopfin_count", int'(count_o), 0);

        // restart coincident with final tick
        do_start(0, 1);
        advance_to_e();
        do_start(0, 5);
        check("restart_tick", int'(tick_o), 1);
        check("restart_expire", int'(expire_o), 0);
        check("restart_count", int'(count_o), 5);
        check("restart_busy", int'(busy_o), 1);
        do_stop();

        // asynchronous reset right after an expiry
        do_start(1, 1);
        wait_tick();
        check("arst_pre_expire", int'(expire_o), 1);
        check("arst_pre_busy", int'(busy_o), 1);
        #2;
        rst_i = 1;
        #1;
        check("arst_busy", int'(busy_o), 0);
        check("arst_count", int'(count_o), 0);
        check("arst_expire", int'(expire_o), 0);
        check("arst_tick", int'(tick_o), 0);
        model_reset();
        repeat (2) cyc();
        rst_i = 0;

        // randomized run
        div_auto = 0; div_rand = 1; div_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            start_i    = ($urandom_range(0, 15) == 0);
            stop_i     = ($urandom_range(0, 39) == 0);
            periodic_i = $urandom;
            load_val_i = W'($urandom_range(0, 6));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
